// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with a frame-synchronous
// double-buffered display word, per-digit blanking and decimal points.

module seg7_hex_dec (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   // Active-low {g,f,e,d,c,b,a}
   always_comb begin
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end
endmodule

module seg7_scan_driver #(
   parameter int unsigned PRESCALE = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data,
   input  logic        load,
   input  logic [7:0]  blank,
   input  logic [7:0]  point,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic [2:0]  digit_idx,
   output logic        frame_done,
   output logic        busy
);
   localparam int unsigned NUM_DIGITS = 8;

   logic [15:0] cnt;
   logic [31:0] shadow;
   logic [31:0] pending;
   logic        tick;
   logic        boundary;
   logic [7:0]  an_nxt;
   logic [7:0]  seg_nxt;
   logic [NUM_DIGITS-1:0][6:0] dec;

   assign tick     = (cnt == 16'(PRESCALE - 1));
   assign boundary = tick && (digit_idx == 3'd7);

   // One decoder per digit; the scan position just selects among them.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
      seg7_hex_dec u_dec (
         .nib (shadow[4*i +: 4]),
         .seg (dec[i])
      );
   end

   always_comb begin
      an_nxt  = ~(8'b1 << digit_idx);
      seg_nxt = {~point[digit_idx], dec[digit_idx]};
      if (blank[digit_idx]) begin
         an_nxt  = 8'hFF;
         seg_nxt = 8'hFF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         digit_idx  <= '0;
         shadow     <= '0;
         pending    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         an         <= 8'hFF;
         seg        <= 8'hFF;
      end else begin
         cnt        <= tick ? '0 : cnt + 16'd1;
         frame_done <= boundary;
         an         <= an_nxt;
         seg        <= seg_nxt;
         if (tick) digit_idx <= digit_idx + 3'd1;
         // A load coinciding with the boundary bypasses pending entirely.
         if (boundary) begin
            if (load)      shadow <= data;
            else if (busy) shadow <= pending;
            busy <= 1'b0;
         end else if (load) begin
            pending <= data;
            busy    <= 1'b1;
         end
      end
   end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter PRESCALE, default 50000, clock cycles each digit is displayed; legal range 2..65535.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 data  input  32  word to display, 8 hex digits; digit i = data[4i+3:4i]; driven by the 8:1 32-bit display-select mux output.
REQ-005 load  input  1  when 1, capture data this cycle.
REQ-006 blank  input  8  per-digit blank mask; 1 = digit i dark; sampled live.
REQ-007 point  input  8  per-digit decimal point; 1 = dp lit; sampled live.
REQ-008 an  output  8  digit enables, active-low, registered.
REQ-009 seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-010 digit_idx  output  3  index of the digit currently being driven.
REQ-011 frame_done  output  1  one-cycle pulse when digit 7 finishes.
REQ-012 busy  output  1  1 while a captured word waits for the next frame boundary.

Function
REQ-013 Prescaler cnt SHALL count 0..PRESCALE-1; tick = (cnt == PRESCALE-1); on tick cnt wraps to 0.
REQ-014 On tick, digit_idx SHALL increment by 1 and wrap from 7 to 0.
REQ-015 Frame boundary = tick with digit_idx == 7; frame_done SHALL be 1 in the cycle after the boundary edge, for exactly one cycle.
REQ-016 load=1 outside a boundary SHALL write data into pending and set busy=1; a later load SHALL overwrite pending; last writer wins.
REQ-017 At a frame boundary with busy=1 and load=0, shadow SHALL take pending and busy SHALL clear.
REQ-018 At a frame boundary with load=1, shadow SHALL take data directly, pending is discarded and busy SHALL clear.
REQ-019 The displayed word (shadow) SHALL change only at frame boundaries; no frame mixes digits of two words.
REQ-020 The an and seg registers SHALL update every cycle from the current digit_idx, shadow, blank and point values; latency is 1 cycle from a digit_idx change to the matching an/seg.
REQ-021 an SHALL be ~(8'b1 << digit_idx) when blank[digit_idx]=0; all 1s (8'hFF) when blank[digit_idx]=1.
REQ-022 seg[6:0] SHALL decode shadow nibble digit_idx, active-low, in hex: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E.
REQ-023 seg[7] SHALL be ~point[digit_idx]; when blank[digit_idx]=1, seg SHALL be 8'hFF.
REQ-024 The block SHALL NOT assert back-pressure; load is always accepted.

Reset
REQ-025 rst_n=0 at a rising edge SHALL set cnt=0, digit_idx=0, shadow=0, pending=0, busy=0, frame_done=0, an=8'hFF, seg=8'hFF.
REQ-026 Reset during a frame or with busy=1 SHALL discard pending data; load is ignored while rst_n=0.
REQ-027 In the first cycle after reset release, an/seg SHALL show digit 0 of shadow=0: an=8'hFE, seg=8'hC0 (blank=0, point=0).

Verification (PRESCALE=4)
REQ-028 Reset, load 32'h76543210 in cycle 1, blank=0, point=0 -> busy=1 until the first boundary (cycle 31); then digits 0..7 show seg C0,F9,A4,B0,99,92,82,F8, each for 4 cycles, with an walking FE,FD,...,7F.
REQ-029 Load 32'hFFFFFFFF mid-frame, then load 32'h00000000 two cycles later -> at the next boundary the shadow is 0 (every digit seg=C0); digits before the boundary still show the old word.
REQ-030 Load asserted exactly on the boundary tick with data=32'hDEADBEEF -> the next frame shows that word; busy stays 0; the pending word from earlier is discarded.
REQ-031 blank=8'h0F, point=8'h80 -> digits 0-3 give an=8'hFF and seg=8'hFF; digit 7 has seg[7]=0.
REQ-032 Free run over 3 frames -> frame_done pulses every 32 cycles, each pulse 1 cycle wide; digit_idx wraps 7->0.
REQ-033 rst_n=0 for 1 cycle mid-frame with busy=1 -> all outputs match REQ-025 on the next edge; busy=0; the next frame displays 0.
